// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer
//   Drives the four board LEDs with a selectable pattern that advances on a
//   rate-selectable tick. The tick is derived from the 100 MHz clock.
//
//   Parameters
//     TICK_DIV   base tick period in clk cycles at sw_speed = 0 (must be >= 8)
//     DB_CYCLES  button debounce stability window in cycles (debounce build only)
//
//   Ports
//     clk_100MHz  in   system clock, the only clock
//     reset       in   asynchronous active-high reset
//     btn_mode    in   async button, a press advances the pattern mode
//     btn_pause   in   async button, a press toggles pause
//     sw_speed    in   async switches, tick period = TICK_DIV >> sw_speed
//     led         out  LED pattern
//     mode        out  0 OFF, 1 BLINK, 2 WALK, 3 BOUNCE
//     paused      out  high while the pattern is frozen
//     tick        out  one-cycle pulse on each pattern step
//
//   Build option
//     BTN_DEBOUNCE_EN  when defined, each synchronized button is filtered so
//                      its level changes only after DB_CYCLES stable cycles.
module led_blink_sequencer #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic [1:0] sw_speed,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       tick
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  // Reject configurations the pattern timing cannot work with.
  if (TICK_DIV < 8 || DB_CYCLES == 0) begin : g_bad_cfg
    $error("led_blink_sequencer: TICK_DIV must be >= 8 and DB_CYCLES >= 1");
  end

  // Two-flop synchronizers for every asynchronous input
  logic       mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic       pause_s1_q, pause_s1_d, pause_s2_q, pause_s2_d;
  logic [1:0] speed_s1_q, speed_s1_d, speed_s2_q, speed_s2_d;

  always_comb begin
    mode_s1_d  = btn_mode;
    mode_s2_d  = mode_s1_q;
    pause_s1_d = btn_pause;
    pause_s2_d = pause_s1_q;
    speed_s1_d = sw_speed;
    speed_s2_d = speed_s1_q;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      mode_s1_q  <= 1'b0;
      mode_s2_q  <= 1'b0;
      pause_s1_q <= 1'b0;
      pause_s2_q <= 1'b0;
      speed_s1_q <= 2'd0;
      speed_s2_q <= 2'd0;
    end else begin
      mode_s1_q  <= mode_s1_d;
      mode_s2_q  <= mode_s2_d;
      pause_s1_q <= pause_s1_d;
      pause_s2_q <= pause_s2_d;
      speed_s1_q <= speed_s1_d;
      speed_s2_q <= speed_s2_d;
    end
  end

  // Filtered button levels
  logic mode_filt, pause_filt;

`ifdef BTN_DEBOUNCE_EN
  logic        mode_filt_q, mode_filt_d, pause_filt_q, pause_filt_d;
  logic [31:0] mode_db_cnt_q, mode_db_cnt_d, pause_db_cnt_q, pause_db_cnt_d;

  // A level flips only after it has disagreed with the filtered level for
  // DB_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    mode_filt_d    = mode_filt_q;
    mode_db_cnt_d  = 32'd0;
    pause_filt_d   = pause_filt_q;
    pause_db_cnt_d = 32'd0;
    if (mode_s2_q != mode_filt_q) begin
      if (mode_db_cnt_q >= 32'(DB_CYCLES - 1)) mode_filt_d = mode_s2_q;
      else                                     mode_db_cnt_d = mode_db_cnt_q + 32'd1;
    end
    if (pause_s2_q != pause_filt_q) begin
      if (pause_db_cnt_q >= 32'(DB_CYCLES - 1)) pause_filt_d = pause_s2_q;
      else                                      pause_db_cnt_d = pause_db_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      mode_filt_q    <= 1'b0;
      mode_db_cnt_q  <= 32'd0;
      pause_filt_q   <= 1'b0;
      pause_db_cnt_q <= 32'd0;
    end else begin
      mode_filt_q    <= mode_filt_d;
      mode_db_cnt_q  <= mode_db_cnt_d;
      pause_filt_q   <= pause_filt_d;
      pause_db_cnt_q <= pause_db_cnt_d;
    end
  end

  assign mode_filt  = mode_filt_q;
  assign pause_filt = pause_filt_q;
`else
  assign mode_filt  = mode_s2_q;
  assign pause_filt = pause_s2_q;
`endif

  // Rising-edge detect on the filtered levels
  logic mode_prev_q, mode_prev_d, pause_prev_q, pause_prev_d;
  logic mode_press, pause_press;

  assign mode_press  = mode_filt & ~mode_prev_q;
  assign pause_press = pause_filt & ~pause_prev_q;

  // Tick generator and pattern state
  logic [31:0] cnt_q, cnt_d, limit;
  logic [3:0]  led_q, led_d;
  logic [1:0]  mode_q, mode_d;
  logic        paused_q, paused_d;
  logic        tick_q, tick_d;
  logic        dir_q, dir_d;   // 0 = shifting left, 1 = shifting right
  logic        step;

  assign limit = 32'(TICK_DIV) >> speed_s2_q;

  always_comb begin
    mode_prev_d  = mode_filt;
    pause_prev_d = pause_filt;
    cnt_d        = cnt_q;
    led_d        = led_q;
    mode_d       = mode_q;
    paused_d     = paused_q;
    dir_d        = dir_q;
    step         = 1'b0;

    // >= rather than == so a shorter limit selected mid-count fires at once
    if (!paused_q) begin
      if (cnt_q >= limit - 32'd1) begin
        step  = 1'b1;
        cnt_d = 32'd0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (step) begin
      case (mode_q)
        MODE_BLINK: led_d = ~led_q;
        MODE_WALK:  led_d = {led_q[2:0], led_q[3]};
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (led_q == 4'b1000) begin
              dir_d = 1'b1;
              led_d = 4'b0100;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q == 4'b0001) begin
              dir_d = 1'b0;
              led_d = 4'b0010;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
        default:    led_d = 4'b0000;
      endcase
    end

    if (pause_press) paused_d = ~paused_q;
    tick_d = step;

    // A mode press overrides everything else on this edge, including a tick
    // and a simultaneous pause press.
    if (mode_press) begin
      mode_d   = mode_q + 2'd1;
      cnt_d    = 32'd0;
      paused_d = 1'b0;
      dir_d    = 1'b0;
      tick_d   = 1'b0;
      led_d    = (mode_d == MODE_WALK || mode_d == MODE_BOUNCE) ? 4'b0001 : 4'b0000;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      mode_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      cnt_q        <= 32'd0;
      led_q        <= 4'b0000;
      mode_q       <= MODE_OFF;
      paused_q     <= 1'b0;
      tick_q       <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      mode_prev_q  <= mode_prev_d;
      pause_prev_q <= pause_prev_d;
      cnt_q        <= cnt_d;
      led_q        <= led_d;
      mode_q       <= mode_d;
      paused_q     <= paused_d;
      tick_q       <= tick_d;
      dir_q        <= dir_d;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed testbench for led_blink_sequencer with TICK_DIV = 8, DB_CYCLES = 4.
// Inputs change 1 ns after a rising clock edge; outputs are sampled there too.
module tb_led_blink_sequencer;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_pause;
  logic [1:0] sw_speed;
  logic [3:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  led_blink_sequencer #(
    .TICK_DIV  (8),
    .DB_CYCLES (4)
  ) dut (
    .clk_100MHz (clk),
    .reset      (rst),
    .btn_mode   (btn_mode),
    .btn_pause  (btn_pause),
    .sw_speed   (sw_speed),
    .led        (led),
    .mode       (mode),
    .paused     (paused),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for the next tick pulse, returning the number of cycles it took.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tick && n < 40);
    if (!tick) check("tick_timeout", 32'(tick), 32'd1);
  endtask

  task automatic press(input logic m, input logic p, input int hold);
    btn_mode  = m;
    btn_pause = p;
    cycles(hold);
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
  endtask

  logic [3:0] mode_led_exp [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
  logic [3:0] walk_exp     [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] bounce_exp   [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [3:0] blink_exp    [3] = '{4'b1111, 4'b0000, 4'b1111};

  initial begin
    int g;
    int tc;
    int mx;
    rst       = 1'b1;
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    sw_speed  = 2'd0;
    cycles(2);
    check("rst_led",    32'(led),    32'd0);
    check("rst_mode",   32'(mode),   32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    check("rst_tick",   32'(tick),   32'd0);
    rst = 1'b0;
    cycles(1);

`ifdef BTN_DEBOUNCE_EN
    // Two-cycle glitch is filtered out
    press(1'b1, 1'b0, 2);
    cycles(10);
    check("db_glitch_mode", 32'(mode), 32'd0);
    // Six-cycle press: mode changes on the 7th edge after the rise
    press(1'b1, 1'b0, 6);
    check("db_press_e6_mode", 32'(mode), 32'd0);
    cycles(1);
    check("db_press_e7_mode", 32'(mode), 32'd1);
    check("db_press_led",     32'(led),  32'd0);
    wait_tick(g);
    check("db_blink_led", 32'(led), 32'hf);
    check("db_blink_gap", 32'(g),   32'd8);
    cycles(12);
    press(1'b1, 1'b0, 6);
    cycles(1);
    check("db_walk_mode",   32'(mode),   32'd2);
    check("db_walk_led",    32'(led),    32'd1);
    check("db_walk_paused", 32'(paused), 32'd0);
`else
    // Mode cycling with entry values
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 1);
      cycles(2);
      check($sformatf("cyc_mode%0d", i), 32'(mode), 32'((i + 1) % 4));
      check($sformatf("cyc_led%0d", i),  32'(led),  32'(mode_led_exp[i]));
    end

    // WALK pattern
    press(1'b1, 1'b0, 1);
    cycles(2);
    check("walk_mode", 32'(mode), 32'd2);
    check("walk_led0", 32'(led),  32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_tick(g);
      check($sformatf("walk_led%0d", i + 1), 32'(led), 32'(walk_exp[i]));
      check($sformatf("walk_gap%0d", i),     32'(g),   32'd8);
    end

    // Pause at 0100, hold 50 cycles, resume
    wait_tick(g);
    check("pause_pre_led", 32'(led), 32'h4);
    press(1'b0, 1'b1, 1);
    cycles(2);
    check("pause_on", 32'(paused), 32'd1);
    tc = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (tick) tc++;
    end
    check("pause_ticks", 32'(tc),  32'd0);
    check("pause_led",   32'(led), 32'h4);
    press(1'b0, 1'b1, 1);
    cycles(2);
    check("pause_off", 32'(paused), 32'd0);
    wait_tick(g);
    check("resume_led", 32'(led), 32'h8);

    // Simultaneous mode and pause press while paused
    press(1'b0, 1'b1, 1);
    cycles(2);
    check("coll_paused_pre", 32'(paused), 32'd1);
    press(1'b1, 1'b1, 1);
    cycles(2);
    check("coll_mode",   32'(mode),   32'd3);
    check("coll_paused", 32'(paused), 32'd0);
    check("coll_led",    32'(led),    32'd1);

    // BOUNCE pattern
    for (int i = 0; i < 7; i++) begin
      wait_tick(g);
      check($sformatf("bounce_led%0d", i), 32'(led), 32'(bounce_exp[i]));
    end

    // Mode press lands on the same edge as a tick
    cycles(5);
    press(1'b1, 1'b0, 1);
    cycles(2);
    check("mt_tick", 32'(tick), 32'd0);
    check("mt_mode", 32'(mode), 32'd0);
    check("mt_led",  32'(led),  32'd0);
    wait_tick(g);
    check("mt_gap", 32'(g), 32'd8);

    // BLINK pattern
    press(1'b1, 1'b0, 1);
    cycles(2);
    check("blink_mode", 32'(mode), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_tick(g);
      check($sformatf("blink_led%0d", i), 32'(led), 32'(blink_exp[i]));
    end

    // Speed switch in WALK
    press(1'b1, 1'b0, 1);
    cycles(2);
    wait_tick(g);
    check("spd0_gap_a", 32'(g), 32'd8);
    wait_tick(g);
    check("spd0_gap_b", 32'(g), 32'd8);
    sw_speed = 2'd2;
    mx = 0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(g);
      if (g > mx) mx = g;
    end
    check("spd_switch_gap_le8", 32'(mx <= 8), 32'd1);
    wait_tick(g);
    check("spd2_gap_a", 32'(g), 32'd2);
    wait_tick(g);
    check("spd2_gap_b", 32'(g), 32'd2);

    // Async reset while paused mid-BOUNCE, no clock edge needed
    press(1'b1, 1'b0, 1);
    cycles(2);
    wait_tick(g);
    wait_tick(g);
    check("arst_pre_led", 32'(led), 32'h4);
    press(1'b0, 1'b1, 1);
    cycles(2);
    check("arst_pre_paused", 32'(paused), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_led",    32'(led),    32'd0);
    check("arst_mode",   32'(mode),   32'd0);
    check("arst_paused", 32'(paused), 32'd0);
    check("arst_tick",   32'(tick),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(2);

    // Without debounce a two-cycle glitch is a press
    press(1'b1, 1'b0, 2);
    cycles(3);
    check("glitch_mode", 32'(mode), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Controller for the board LED blink datapath. Generates a rate-selectable tick from the 100 MHz clock and steps an LED pattern FSM on each tick.
- Pattern mode, pause and speed are set from PYNQ-Z2 buttons and switches.
- Sits between the raw board I/O and the 4 LEDs. Replaces the free-running fixed divider in the LED blink lab.

Parameters:
- TICK_DIV, 25_000_000, base tick period in clk cycles at sw_speed=0 (4 Hz); must be >= 8.
- DB_CYCLES, 1_000_000, debounce stability window in cycles; used only with BTN_DEBOUNCE_EN.

Ports:
- clk_100MHz  in   1  system clock, 100 MHz; the only clock.
- reset       in   1  asynchronous, active-high reset.
- btn_mode    in   1  asynchronous button; a press advances the pattern mode.
- btn_pause   in   1  asynchronous button; a press toggles pause.
- sw_speed    in   2  asynchronous switches; tick period = TICK_DIV >> sw_speed.
- led         out  4  LED pattern.
- mode        out  2  current mode: 0 OFF, 1 BLINK, 2 WALK, 3 BOUNCE.
- paused      out  1  high while paused.
- tick        out  1  one-cycle pulse on each pattern step.

Behaviour:
- Reset (async, immediate): led=0000, mode=0, paused=0, tick=0, tick counter=0, direction=left, all synchronizer, edge and debounce registers=0.
- Input conditioning: btn_mode, btn_pause and sw_speed each pass through a 2-FF synchronizer.
- Each button then has a rising-edge detect register. This gives a one-cycle press pulse on the 3rd rising edge after the input goes high. Holding a button produces exactly one pulse.
- Tick generation: limit = TICK_DIV >> sw_speed_sync, using a 32-bit counter.
  - When counter >= limit-1: tick=1 for one cycle and counter resets to 0. Otherwise the counter increments.
  - The >= compare makes a speed change mid-count safe: if the count is already past the new limit, the tick fires on the next cycle.
  - While paused, the counter holds and tick stays 0.
- Mode press (highest priority):
  - mode <= mode+1, wrapping from 3 to 0.
  - counter <= 0, paused <= 0, direction <= left.
  - led loads the new mode's entry value on the same edge.
  - A tick in that same cycle is discarded.
- Pause press (no mode press in the same cycle): paused toggles. A pause press coincident with a mode press is ignored.
- Entry values: OFF 0000, BLINK 0000, WALK 0001, BOUNCE 0001.
- Per-tick step:
  - OFF: led stays 0000.
  - BLINK: led <= ~led, so 0000 -> 1111 -> 0000.
  - WALK: rotate left, 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - BOUNCE: shift in the current direction; direction reverses at 1000 and at 0001. Sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
- led, mode and paused are registered outputs updated on the clk edge. tick is registered and aligned with the edge that updates led.
- The pattern stays frozen while paused. Resuming continues from the held led value and the held counter value.

Optional Feature:
- Macro: BTN_DEBOUNCE_EN.
- Defined:
  - Each synchronized button drives a counter. The filtered level changes only after the raw level differs from the filtered level for DB_CYCLES consecutive cycles.
  - Any bounce back to the filtered level clears that counter.
  - Edge detect runs on the filtered level, so press latency is 3+DB_CYCLES cycles.
- Undefined: the filtered level equals the synchronized level; no debounce logic is present.

Test Plan:
- Speed: TICK_DIV=8, mode=WALK, sw_speed=0 -> tick every 8 cycles. Switch to sw_speed=2 -> within 3 sync cycles, tick every 2 cycles, and no tick gap exceeds 8 cycles during the switch.
- Mode cycling: 5 btn_mode presses from reset -> mode goes 1,2,3,0,1; led shows the entry value each time (0000, 0001, 0001, 0000, 0000).
- Patterns, TICK_DIV=8:
  - WALK over 5 ticks -> led 0010, 0100, 1000, 0001, 0010.
  - BOUNCE over 7 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - BLINK over 3 ticks -> 1111, 0000, 1111.
- Pause: in WALK at led=0100, press btn_pause -> paused=1, no tick for 50 cycles, led stays 0100. Press again -> paused=0, next tick gives led=1000.
- Collisions:
  - btn_mode and btn_pause pulses in the same cycle while paused=1 -> mode increments and paused=0.
  - A mode press in the same cycle as a tick -> no pattern step, counter=0.
  - Async reset asserted mid-BOUNCE -> all outputs 0 immediately, with no clock needed.
- With BTN_DEBOUNCE_EN, DB_CYCLES=4:
  - A 2-cycle glitch on btn_mode -> no mode change.
  - A 6-cycle press -> one increment, 7 cycles after the rise.
  - Without the macro, the same glitch -> one increment.
